// File: rtl/arbitro_bus_datos_if.sv
// Shared data-bus bundle between the two masters (CPU, DMA), the arbiter
// and the downstream write driver / read mux.
// The master modport is the requester side; slave is the arbiter side.
interface arbitro_bus_datos_if;
  // CPU master
  logic        req_cpu_i;
  logic [31:0] address_cpu_i;
  logic        we_cpu_i;
  logic [31:0] wdata_cpu_i;
  logic        gnt_cpu_o;
  logic        done_cpu_o;
  logic [31:0] rdata_cpu_o;
  // DMA master
  logic        req_dma_i;
  logic [31:0] address_dma_i;
  logic        we_dma_i;
  logic [31:0] wdata_dma_i;
  logic        gnt_dma_o;
  logic        done_dma_o;
  logic [31:0] rdata_dma_o;
  // Shared bus
  logic [31:0] address_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i;
  logic        busy_o;

  modport slave (
    input  req_cpu_i, address_cpu_i, we_cpu_i, wdata_cpu_i,
    output gnt_cpu_o, done_cpu_o, rdata_cpu_o,
    input  req_dma_i, address_dma_i, we_dma_i, wdata_dma_i,
    output gnt_dma_o, done_dma_o, rdata_dma_o,
    output address_o, we_o, wdata_o, busy_o,
    input  rdata_i
  );

  modport master (
    output req_cpu_i, address_cpu_i, we_cpu_i, wdata_cpu_i,
    input  gnt_cpu_o, done_cpu_o, rdata_cpu_o,
    output req_dma_i, address_dma_i, we_dma_i, wdata_dma_i,
    input  gnt_dma_o, done_dma_o, rdata_dma_o,
    input  address_o, we_o, wdata_o, busy_o,
    output rdata_i
  );
endinterface

// File: rtl/arbitro_bus_datos.sv
// Two-master (CPU / DMA) arbiter for the shared memory-mapped data bus.
// Each access holds address/wdata for ACCESS_CYCLES cycles and pulses we_o
// once on the last cycle. CPU has fixed priority, bounded by a streak limit
// so a requesting DMA is not starved.
// Optional macro DMA_RAM_ONLY_EN: DMA writes outside 0x1000..0x13FC are
// suppressed on we_o (the access still runs and done_dma_o still pulses).
module arbitro_bus_datos #(
  parameter int unsigned ACCESS_CYCLES  = 2,
  parameter int unsigned MAX_CPU_STREAK = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  arbitro_bus_datos_if.slave  bus_io
);

  localparam logic [3:0] AccLast   = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] MaxStreak = 4'(MAX_CPU_STREAK);

  typedef enum logic {StIdle, StAccess} state_e;
  typedef enum logic {OwnCpu, OwnDma}   owner_e;

  state_e      state_q;
  owner_e      owner_q;
  logic [3:0]  cnt_q;
  logic [3:0]  streak_q;
  logic        gnt_cpu_q, gnt_dma_q, busy_q;
  logic        done_cpu_q, done_dma_q;
  logic [31:0] rdata_cpu_q, rdata_dma_q;

  logic        valid_cpu, valid_dma, pick_dma;
  logic [31:0] own_addr, own_wdata;
  logic        own_we, dma_wr_ok, last_cycle;

  // Request qualification and grant choice for the IDLE state
  always_comb begin
    // A master in its done cycle is not re-granted even if req is still high
    valid_cpu = bus_io.req_cpu_i & ~done_cpu_q;
    valid_dma = bus_io.req_dma_i & ~done_dma_q;
    pick_dma  = valid_dma & (~valid_cpu | (streak_q == MaxStreak));
  end

  // Owner mux onto the shared bus; we_o is a single pulse on the last cycle
  always_comb begin
    own_addr  = '0;
    own_wdata = '0;
    own_we    = 1'b0;
    if (state_q == StAccess) begin
      if (owner_q == OwnCpu) begin
        own_addr  = bus_io.address_cpu_i;
        own_wdata = bus_io.wdata_cpu_i;
        own_we    = bus_io.we_cpu_i;
      end else begin
        own_addr  = bus_io.address_dma_i;
        own_wdata = bus_io.wdata_dma_i;
        own_we    = bus_io.we_dma_i;
      end
    end
`ifdef DMA_RAM_ONLY_EN
    dma_wr_ok = (bus_io.address_dma_i >= 32'h0000_1000) &&
                (bus_io.address_dma_i <= 32'h0000_13FC);
`else
    dma_wr_ok = 1'b1;
`endif
    last_cycle = (state_q == StAccess) && (cnt_q == 4'd0);
    // Reset kills the access at once, so the pulse must not escape that cycle
    bus_io.we_o = last_cycle & own_we & ~rst_i & ((owner_q == OwnCpu) | dma_wr_ok);
    bus_io.address_o = own_addr;
    bus_io.wdata_o   = own_wdata;
  end

  // Arbitration / access sequencing FSM with registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      owner_q     <= OwnCpu;
      cnt_q       <= '0;
      streak_q    <= '0;
      gnt_cpu_q   <= 1'b0;
      gnt_dma_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_cpu_q  <= 1'b0;
      done_dma_q  <= 1'b0;
      rdata_cpu_q <= '0;
      rdata_dma_q <= '0;
    end else begin
      done_cpu_q <= 1'b0;
      done_dma_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!bus_io.req_dma_i) streak_q <= '0;
          if (valid_cpu || valid_dma) begin
            state_q <= StAccess;
            cnt_q   <= AccLast;
            busy_q  <= 1'b1;
            if (pick_dma) begin
              owner_q   <= OwnDma;
              gnt_dma_q <= 1'b1;
              streak_q  <= '0;
            end else begin
              owner_q   <= OwnCpu;
              gnt_cpu_q <= 1'b1;
              if (bus_io.req_dma_i && (streak_q != 4'hF)) streak_q <= streak_q + 4'd1;
            end
          end
        end
        StAccess: begin
          if (cnt_q == 4'd0) begin
            state_q   <= StIdle;
            gnt_cpu_q <= 1'b0;
            gnt_dma_q <= 1'b0;
            busy_q    <= 1'b0;
            if (owner_q == OwnCpu) begin
              done_cpu_q <= 1'b1;
              if (!bus_io.we_cpu_i) rdata_cpu_q <= bus_io.rdata_i;
            end else begin
              done_dma_q <= 1'b1;
              if (!bus_io.we_dma_i) rdata_dma_q <= bus_io.rdata_i;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.gnt_cpu_o   = gnt_cpu_q;
  assign bus_io.gnt_dma_o   = gnt_dma_q;
  assign bus_io.busy_o      = busy_q;
  assign bus_io.done_cpu_o  = done_cpu_q;
  assign bus_io.done_dma_o  = done_dma_q;
  assign bus_io.rdata_cpu_o = rdata_cpu_q;
  assign bus_io.rdata_dma_o = rdata_dma_q;

endmodule
